// File: rtl/unified_memory_arbiter_if.sv
// Bundle of fetch, data and RAM-side signals around the unified memory arbiter.
// master = pipeline plus RAM environment, slave = arbiter.
interface unified_memory_arbiter_if;
   logic        ifRequest;
   logic [31:0] ifAddress;
   logic [31:0] ifReadData;
   logic        ifValid;
   logic        ifStall;

   logic        memRequest;
   logic        memShouldWrite;
   logic [31:0] memAddress;
   logic [31:0] memWriteData;
   logic [31:0] memReadData;
   logic        memValid;
   logic        memStall;

   logic        ramEnable;
   logic        ramWriteEnable;
   logic [31:0] ramAddress;
   logic [31:0] ramWriteData;
   logic [31:0] ramReadData;

   logic        busy;

   modport master (
      output ifRequest, ifAddress,
      output memRequest, memShouldWrite, memAddress, memWriteData,
      output ramReadData,
      input  ifReadData, ifValid, ifStall,
      input  memReadData, memValid, memStall,
      input  ramEnable, ramWriteEnable, ramAddress, ramWriteData,
      input  busy
   );

   modport slave (
      input  ifRequest, ifAddress,
      input  memRequest, memShouldWrite, memAddress, memWriteData,
      input  ramReadData,
      output ifReadData, ifValid, ifStall,
      output memReadData, memValid, memStall,
      output ramEnable, ramWriteEnable, ramAddress, ramWriteData,
      output busy
   );
endinterface

// File: rtl/unified_memory_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and data access, one access at a
// time, with data priority, a fetch starvation guard and programmable wait states.
module unified_memory_arbiter #(
   parameter int unsigned WAIT_STATES  = 0,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                    clock,
   input logic                    reset,
   unified_memory_arbiter_if.slave bus
);

   localparam logic [3:0] WaitInit  = 4'(WAIT_STATES);
   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_t;

   state_t      state;
   state_t      stateNext;
   logic        ownerMem;
   logic [31:0] latchedAddress;
   logic        latchedWrite;
   logic [31:0] latchedWriteData;
   logic [3:0]  waitCount;
   logic [3:0]  starveCount;
   logic [31:0] ifData;
   logic [31:0] memData;

   logic anyRequest;
   logic grantIf;

   assign anyRequest = bus.ifRequest | bus.memRequest;
   // Data wins by default; fetch wins once it has lost STARVE_LIMIT contended grants in a row.
   assign grantIf    = bus.ifRequest & (~bus.memRequest | (starveCount == StarveMax));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= StIdle;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         StIdle:    if (anyRequest) stateNext = StAccess;
         StAccess:  if (waitCount == 4'd0) stateNext = StRespond;
         StRespond: stateNext = StIdle;
         default:   stateNext = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ownerMem         <= 1'b0;
         latchedAddress   <= 32'd0;
         latchedWrite     <= 1'b0;
         latchedWriteData <= 32'd0;
         waitCount        <= 4'd0;
         starveCount      <= 4'd0;
         ifData           <= 32'd0;
         memData          <= 32'd0;
      end else begin
         case (state)
            StIdle: begin
               if (anyRequest) begin
                  ownerMem         <= ~grantIf;
                  latchedAddress   <= grantIf ? bus.ifAddress : bus.memAddress;
                  latchedWrite     <= ~grantIf & bus.memShouldWrite;
                  latchedWriteData <= grantIf ? 32'd0 : bus.memWriteData;
                  waitCount        <= WaitInit;
                  if (grantIf) begin
                     starveCount <= 4'd0;
                  end else if (bus.ifRequest && starveCount != StarveMax) begin
                     starveCount <= starveCount + 4'd1;
                  end
               end
            end
            StAccess: begin
               if (waitCount != 4'd0) begin
                  waitCount <= waitCount - 4'd1;
               end else if (ownerMem) begin
                  memData <= latchedWrite ? 32'd0 : bus.ramReadData;
               end else begin
                  ifData <= bus.ramReadData;
               end
            end
            default: ;
         endcase
      end
   end

   // RAM strobes derive from state so an asynchronous reset drops them immediately.
   assign bus.ramEnable      = (state == StAccess);
   assign bus.ramWriteEnable = bus.ramEnable & latchedWrite;
   assign bus.ramAddress     = bus.ramEnable ? latchedAddress : 32'd0;
   assign bus.ramWriteData   = bus.ramEnable ? latchedWriteData : 32'd0;

   assign bus.ifValid     = (state == StRespond) & ~ownerMem;
   assign bus.memValid    = (state == StRespond) & ownerMem;
   assign bus.ifStall     = bus.ifRequest & ~bus.ifValid;
   assign bus.memStall    = bus.memRequest & ~bus.memValid;
   assign bus.ifReadData  = ifData;
   assign bus.memReadData = memData;
   assign bus.busy        = (state != StIdle);

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed bench: vector table on a zero-wait instance, hand sequences on a three-wait instance.
module tb_unified_memory_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clock = ~clock;

   unified_memory_arbiter_if bus0 ();
   unified_memory_arbiter_if bus3 ();

   unified_memory_arbiter #(.WAIT_STATES(0), .STARVE_LIMIT(4)) dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (bus0)
   );

   unified_memory_arbiter #(.WAIT_STATES(3), .STARVE_LIMIT(4)) dut3 (
      .clock (clock),
      .reset (reset),
      .bus   (bus3)
   );

   typedef struct {
      logic        isMem;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] expData;
      logic        expWe;
      logic [31:0] expWd;
      logic [31:0] expOther;
   } vec_t;

   vec_t vecs[5];
   logic expMem[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   valids;
      int   ifValids;
      logic found;
      logic ownerIsMem;

      bus0.ifRequest = 0; bus0.ifAddress = 0; bus0.memRequest = 0; bus0.memShouldWrite = 0;
      bus0.memAddress = 0; bus0.memWriteData = 0; bus0.ramReadData = 0;
      bus3.ifRequest = 0; bus3.ifAddress = 0; bus3.memRequest = 0; bus3.memShouldWrite = 0;
      bus3.memAddress = 0; bus3.memWriteData = 0; bus3.ramReadData = 0;

      //          isMem wr  addr          wdata         rdata         expData       we  expWd  other
      vecs[0] = '{1'b0, 1'b0, 32'h00000010, 32'h0, 32'h8C010004, 32'h8C010004, 1'b0, 32'h0,
                  32'h0};
      vecs[1] = '{1'b1, 1'b0, 32'h00000100, 32'h0, 32'h12345678, 32'h12345678, 1'b0, 32'h0,
                  32'h8C010004};
      vecs[2] = '{1'b1, 1'b1, 32'h00000200, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h0, 1'b1,
                  32'hA5A5A5A5, 32'h8C010004};
      vecs[3] = '{1'b0, 1'b1, 32'hFFFFFFFC, 32'h55AA55AA, 32'h0BADF00D, 32'h0BADF00D, 1'b0,
                  32'h0, 32'h0};
      vecs[4] = '{1'b1, 1'b0, 32'h00000003, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 32'h0,
                  32'h0BADF00D};
      expMem = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

      doReset();
      chkb("reset busy", bus0.busy, 1'b0);
      chkb("reset ramEnable", bus0.ramEnable, 1'b0);
      chkb("reset ifValid", bus0.ifValid, 1'b0);
      chkb("reset memValid", bus0.memValid, 1'b0);
      chk("reset ifReadData", bus0.ifReadData, 32'h0);
      chk("reset memReadData", bus0.memReadData, 32'h0);
      chk("reset ramAddress", bus0.ramAddress, 32'h0);
      chk("reset starveCount", 32'(dut0.starveCount), 32'h0);

      // Single-requester transactions, zero wait states.
      for (int i = 0; i < 5; i++) begin
         bus0.ifAddress      = vecs[i].isMem ? ~vecs[i].addr : vecs[i].addr;
         bus0.memAddress     = vecs[i].isMem ? vecs[i].addr : ~vecs[i].addr;
         bus0.memShouldWrite = vecs[i].wr;
         bus0.memWriteData   = vecs[i].wdata;
         bus0.ramReadData    = vecs[i].rdata;
         bus0.ifRequest      = ~vecs[i].isMem;
         bus0.memRequest     = vecs[i].isMem;
         #1;
         chkb("vec stall t", vecs[i].isMem ? bus0.memStall : bus0.ifStall, 1'b1);
         chkb("vec busy t", bus0.busy, 1'b0);
         step();
         chkb("vec busy t+1", bus0.busy, 1'b1);
         chkb("vec ramEnable t+1", bus0.ramEnable, 1'b1);
         chkb("vec ramWriteEnable", bus0.ramWriteEnable, vecs[i].expWe);
         chk("vec ramAddress", bus0.ramAddress, vecs[i].addr);
         chk("vec ramWriteData", bus0.ramWriteData, vecs[i].expWd);
         chkb("vec stall t+1", vecs[i].isMem ? bus0.memStall : bus0.ifStall, 1'b1);
         step();
         chkb("vec owner valid", vecs[i].isMem ? bus0.memValid : bus0.ifValid, 1'b1);
         chkb("vec other valid", vecs[i].isMem ? bus0.ifValid : bus0.memValid, 1'b0);
         chkb("vec ramEnable t+2", bus0.ramEnable, 1'b0);
         chkb("vec stall t+2", vecs[i].isMem ? bus0.memStall : bus0.ifStall, 1'b0);
         chk("vec read data", vecs[i].isMem ? bus0.memReadData : bus0.ifReadData,
             vecs[i].expData);
         chk("vec other data hold", vecs[i].isMem ? bus0.ifReadData : bus0.memReadData,
             vecs[i].expOther);
         bus0.ifRequest  = 0;
         bus0.memRequest = 0;
         step();
         chkb("vec idle busy", bus0.busy, 1'b0);
      end

      // Continuous contention: fetch must win the fifth grant.
      bus0.ifAddress = 32'h1000; bus0.memAddress = 32'h2000; bus0.memShouldWrite = 0;
      bus0.ifRequest = 1; bus0.memRequest = 1;
      for (int g = 0; g < 7; g++) begin
         found = 0;
         for (int k = 0; k < 20 && !found; k++) begin
            if (bus0.ifValid || bus0.memValid) found = 1;
            else step();
         end
         chkb("grant seen", found, 1'b1);
         ownerIsMem = bus0.memValid;
         chkb("grant order", ownerIsMem, expMem[g]);
         if (g == 4) chk("starve cleared", 32'(dut0.starveCount), 32'h0);
         step();
      end
      bus0.ifRequest = 0; bus0.memRequest = 0;
      step(); step(); step();

      doReset();

      // Three wait states: a read, then a write whose read data must be zero.
      bus3.memAddress = 32'h44; bus3.memShouldWrite = 0; bus3.ramReadData = 32'h11112222;
      bus3.memRequest = 1;
      for (int k = 1; k <= 5; k++) begin
         step();
         if (k < 5) begin
            chkb("ws3 rd ramEnable", bus3.ramEnable, 1'b1);
            chkb("ws3 rd early valid", bus3.memValid, 1'b0);
         end else begin
            chkb("ws3 rd valid", bus3.memValid, 1'b1);
            chk("ws3 rd data", bus3.memReadData, 32'h11112222);
         end
      end
      bus3.memRequest = 0;
      step();

      bus3.memAddress = 32'h40; bus3.memShouldWrite = 1; bus3.memWriteData = 32'hDEADBEEF;
      bus3.ramReadData = 32'h77777777; bus3.memRequest = 1;
      for (int k = 1; k <= 5; k++) begin
         step();
         if (k <= 4) begin
            chkb("ws3 wr we", bus3.ramWriteEnable, 1'b1);
            chk("ws3 wr addr", bus3.ramAddress, 32'h40);
            chk("ws3 wr data", bus3.ramWriteData, 32'hDEADBEEF);
            chkb("ws3 wr early valid", bus3.memValid, 1'b0);
         end else begin
            chkb("ws3 wr valid", bus3.memValid, 1'b1);
            chkb("ws3 wr we off", bus3.ramWriteEnable, 1'b0);
            chk("ws3 wr readdata", bus3.memReadData, 32'h0);
         end
      end
      bus3.memRequest = 0; bus3.memShouldWrite = 0;
      step();

      // Inputs change mid-access and data request is withdrawn; fetch is served next.
      bus3.memAddress = 32'h80; bus3.ifAddress = 32'h90; bus3.ramReadData = 32'h13572468;
      bus3.memRequest = 1; bus3.ifRequest = 1;
      valids = 0; ifValids = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (bus3.memValid) valids++;
         if (bus3.ifValid) ifValids++;
         if (k == 1) begin
            chk("midacc addr k1", bus3.ramAddress, 32'h80);
            bus3.memAddress = 32'h1234;
         end
         if (k == 2) begin
            chk("midacc addr k2", bus3.ramAddress, 32'h80);
            bus3.memRequest = 0;
         end
         if (k == 3) begin
            chk("midacc addr k3", bus3.ramAddress, 32'h80);
            chkb("midacc memStall", bus3.memStall, 1'b0);
         end
         if (k == 5) begin
            chkb("midacc memValid", bus3.memValid, 1'b1);
            chk("midacc memReadData", bus3.memReadData, 32'h13572468);
         end
         if (k == 7) begin
            chkb("midacc if ramEnable", bus3.ramEnable, 1'b1);
            chk("midacc if addr", bus3.ramAddress, 32'h90);
            bus3.ramReadData = 32'h2468ACE0;
         end
         if (k == 11) begin
            chkb("midacc ifValid", bus3.ifValid, 1'b1);
            chk("midacc ifReadData", bus3.ifReadData, 32'h2468ACE0);
            bus3.ifRequest = 0;
         end
      end
      chk("midacc mem pulses", 32'(valids), 32'd1);
      chk("midacc if pulses", 32'(ifValids), 32'd1);

      // Reset in the second access cycle of a contended write.
      bus3.memAddress = 32'h60; bus3.memShouldWrite = 1; bus3.memWriteData = 32'h0F0F0F0F;
      bus3.ifAddress = 32'h70; bus3.memRequest = 1; bus3.ifRequest = 1;
      step();
      step();
      chkb("rst pre ramEnable", bus3.ramEnable, 1'b1);
      chkb("rst pre we", bus3.ramWriteEnable, 1'b1);
      #2;
      reset = 1'b1;
      bus3.memRequest = 0; bus3.ifRequest = 0; bus3.memShouldWrite = 0;
      #1;
      chkb("rst ramEnable drop", bus3.ramEnable, 1'b0);
      chkb("rst we drop", bus3.ramWriteEnable, 1'b0);
      chkb("rst busy drop", bus3.busy, 1'b0);
      step();
      step();
      reset = 1'b0;
      valids = 0;
      for (int k = 0; k < 6; k++) begin
         if (bus3.memValid || bus3.ifValid) valids++;
         step();
      end
      chk("rst no valid", 32'(valids), 32'd0);
      chkb("rst after busy", bus3.busy, 1'b0);
      chk("rst after state", 32'(dut3.state), 32'd0);
      chk("rst after starve", 32'(dut3.starveCount), 32'd0);

      bus3.ifAddress = 32'h70; bus3.ramReadData = 32'h600DCAFE; bus3.ifRequest = 1;
      for (int k = 1; k <= 5; k++) begin
         step();
         if (k == 4) chkb("post rst early", bus3.ifValid, 1'b0);
         if (k == 5) begin
            chkb("post rst ifValid", bus3.ifValid, 1'b1);
            chk("post rst ifReadData", bus3.ifReadData, 32'h600DCAFE);
         end
      end
      bus3.ifRequest = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
